// File: rtl/dpram_pkg.sv
// Shared types and helpers for the byte-enabled dual-port RAM with hardware clear.
package dpram_pkg;

   localparam int unsigned LANE_W = 8;

   typedef enum logic {RDW_NEW = 1'b0, RDW_OLD = 1'b1} rdw_mode_e;
   typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} clr_state_e;

   // Number of byte lanes; the top lane may be partial.
   function automatic int unsigned lanes(input int unsigned width);
      return (width + LANE_W - 1) / LANE_W;
   endfunction

endpackage

// File: rtl/dpram_clr_ctrl.sv
// Clear engine: after reset, sweeps every address once writing CLR_VALUE, holding busy
// high until the last word is written.
module dpram_clr_ctrl
   import dpram_pkg::*;
#(
   parameter int aWidth = 10,
   parameter int dWidth = 8,
   parameter logic [dWidth-1:0] CLR_VALUE = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              busy,
   output logic              clr_we,
   output logic [aWidth-1:0] clr_addr,
   output logic [dWidth-1:0] clr_data
);

   clr_state_e        state;
   logic [aWidth-1:0] clr_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= CLEAR;
         clr_cnt <= '0;
         busy    <= 1'b1;
      end else if (state == CLEAR) begin
         clr_cnt <= clr_cnt + 1'b1;
         if (clr_cnt == {aWidth{1'b1}}) begin
            state <= RUN;
            busy  <= 1'b0;
         end
      end
   end

   assign clr_we   = (state == CLEAR) && !reset;
   assign clr_addr = clr_cnt;
   assign clr_data = CLR_VALUE;

endmodule

// File: rtl/dpram_be_clr.sv
// True dual-port RAM with byte enables, selectable read-during-write and a power-up clear.
// Define DPRAM_BE_CLR_OREG_EN to add an output register stage (read latency 2).
module dpram_be_clr
   import dpram_pkg::*;
#(
   parameter int dWidth   = 8,
   parameter int aWidth   = 10,
   parameter int RDW_MODE = 0,
   parameter logic [dWidth-1:0] CLR_VALUE = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   output logic                      busy,
   input  logic                      we_a,
   input  logic [lanes(dWidth)-1:0]  be_a,
   input  logic [aWidth-1:0]         addr_a,
   input  logic [dWidth-1:0]         d_a,
   output logic [dWidth-1:0]         q_a,
   input  logic                      we_b,
   input  logic [lanes(dWidth)-1:0]  be_b,
   input  logic [aWidth-1:0]         addr_b,
   input  logic [dWidth-1:0]         d_b,
   output logic [dWidth-1:0]         q_b
);

   localparam int DEPTH = 2 ** aWidth;
   localparam rdw_mode_e RDW = (RDW_MODE == 0) ? RDW_NEW : RDW_OLD;

   logic [dWidth-1:0] mem [DEPTH];

   logic              core_busy, blk, port_en, clr_we, collide;
   logic [aWidth-1:0] clr_addr;
   logic [dWidth-1:0] clr_data;
   logic [dWidth-1:0] mask_a, mask_b, old_a, old_b, new_a, new_b, rd_a, rd_b;
   logic [dWidth-1:0] q1_a, q1_b;

   dpram_clr_ctrl #(
      .aWidth    (aWidth),
      .dWidth    (dWidth),
      .CLR_VALUE (CLR_VALUE)
   ) u_clr_ctrl (
      .clk      (clk),
      .reset    (reset),
      .busy     (core_busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .clr_data (clr_data)
   );

   always_comb begin
      mask_a = '0;
      mask_b = '0;
      for (int b = 0; b < dWidth; b++) begin
         mask_a[b] = we_a & be_a[b / LANE_W];
         mask_b[b] = we_b & be_b[b / LANE_W];
      end
   end

   assign old_a   = mem[addr_a];
   assign old_b   = mem[addr_b];
   assign collide = we_a && we_b && (addr_a == addr_b);

   // On a same-address collision B's merge is the base and A's lanes land on top,
   // so new_a is the final word and A wins every overlapping lane.
   assign new_b = (old_b & ~mask_b) | (d_b & mask_b);
   assign new_a = ((collide ? new_b : old_a) & ~mask_a) | (d_a & mask_a);

   assign rd_a = (RDW == RDW_NEW && we_a) ? new_a : old_a;
   assign rd_b = (RDW == RDW_NEW && we_b) ? (collide ? new_a : new_b) : old_b;

   assign port_en = !blk && !reset;

   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= clr_data;
      end else if (port_en) begin
         if (we_b) mem[addr_b] <= new_b;
         if (we_a) mem[addr_a] <= new_a;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || blk) begin
         q1_a <= '0;
         q1_b <= '0;
      end else begin
         q1_a <= rd_a;
         q1_b <= rd_b;
      end
   end

`ifdef DPRAM_BE_CLR_OREG_EN
   logic              busy_dly;
   logic [dWidth-1:0] q2_a, q2_b;

   // busy trails the clear engine by one cycle so it stays aligned with q.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_dly <= 1'b1;
         q2_a     <= '0;
         q2_b     <= '0;
      end else begin
         busy_dly <= core_busy;
         q2_a     <= q1_a;
         q2_b     <= q1_b;
      end
   end

   assign blk  = busy_dly;
   assign busy = busy_dly;
   assign q_a  = q2_a;
   assign q_b  = q2_b;
`else
   assign blk  = core_busy;
   assign busy = core_busy;
   assign q_a  = q1_a;
   assign q_b  = q1_b;
`endif

endmodule
